// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
// Shared types and helpers for the nested-interrupt context controller.
//   level_t      : 2-bit execution level (0 = user, 1..3 = interrupt levels)
//   state_t      : controller FSM states (RUN, SAVE, RESTORE)
//   level_vector : handler entry address for a given level
//   level_onehot : one-hot select of the register-file bank owned by a level
// -----------------------------------------------------------------------------
package irq_pkg;

    typedef logic [1:0] level_t;

    localparam level_t LVL_USER = 2'd0;
    localparam level_t LVL_1    = 2'd1;
    localparam level_t LVL_2    = 2'd2;
    localparam level_t LVL_3    = 2'd3;

    // Number of interrupt levels; also the maximum nesting depth, since every
    // take strictly raises the level.
    localparam int NUM_LEVELS = 3;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SAVE    = 2'd1,
        RESTORE = 2'd2
    } state_t;

    // Level L handler lives at base + (L-1)*stride. Only called with L >= 1.
    function automatic logic [31:0] level_vector(
        input logic [31:0] base,
        input logic [31:0] stride,
        input level_t      lvl
    );
        logic [31:0] idx;
        idx          = {30'd0, lvl} - 32'd1;
        level_vector = base + idx * stride;
    endfunction

    // Bank select for the level being backed up or restored:
    // 0 -> user bank, 1 -> bank 1, 2 -> bank 2. Level 3 never owns a saved bank.
    function automatic logic [2:0] level_onehot(input level_t lvl);
        logic [2:0] sel;
        sel = 3'b000;
        case (lvl)
            LVL_USER: sel = 3'b001;
            LVL_1:    sel = 3'b010;
            LVL_2:    sel = 3'b100;
            default:  sel = 3'b000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
// Combinational masked priority encoder over the three interrupt levels.
// Bit k of req corresponds to level k+1; the highest unmasked bit wins.
//   req    in  3  pending requests
//   mask   in  3  1 = level masked
//   valid  out 1  at least one unmasked request
//   level  out 2  winning level (LVL_USER when valid = 0)
// -----------------------------------------------------------------------------
module irq_prio_enc
    import irq_pkg::*;
(
    input  logic [2:0] req,
    input  logic [2:0] mask,
    output logic       valid,
    output level_t     level
);

    logic [2:0] eligible;

    // NOTE: every output of a combinational block gets a default before any
    // branch so that no path leaves it unassigned and infers a latch.
    always_comb begin
        eligible = req & ~mask;
        valid    = |eligible;
        level    = LVL_USER;
        if (eligible[2]) begin
            level = LVL_3;
        end else if (eligible[1]) begin
            level = LVL_2;
        end else if (eligible[0]) begin
            level = LVL_1;
        end
    end

endmodule

// File: rtl/irq_ctx_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctx_ctrl
// Nested-interrupt context controller in front of the CPU register file.
// Latches three prioritised interrupt requests, decides when to preempt,
// drives the register-file backup/restore strobes, and keeps a per-level EPC
// stack so ERET can return to the interrupted context.
//
// Ports
//   clk                 in   1  system clock
//   rst                 in   1  synchronous active-high reset
//   int_en              in   1  global interrupt enable
//   irq_in              in   3  request pulses, bit k -> level k+1
//   irq_mask            in   3  1 = level masked (kept pending)
//   eret                in   1  ERET commit pulse
//   pc_in               in  32  resume PC of the next instruction
//   take_irq            out  1  redirect-to-handler pulse
//   eret_jump           out  1  redirect-to-EPC pulse
//   redirect_pc         out 32  target PC while take_irq/eret_jump is high
//   stall               out  1  freeze pipeline/RF writes during SAVE/RESTORE
//   enable_userBackUp   out  1  back up user bank
//   enable_BackUp1      out  1  back up level-1 bank
//   enable_BackUp2      out  1  back up level-2 bank
//   restore_userBackUp  out  1  restore user bank
//   restore_BackUp1     out  1  restore level-1 bank
//   restore_BackUp2     out  1  restore level-2 bank
//   cur_level           out  2  current execution level, 0 = user
//   pending             out  3  latched pending requests
//
// Timing: the RUN-cycle decision is registered, so all strobes, take_irq /
// eret_jump, redirect_pc and stall are high for exactly the one SAVE or
// RESTORE cycle. Stack pushes, level changes and the pending clear are
// committed on the edge that leaves SAVE/RESTORE.
// -----------------------------------------------------------------------------
module irq_ctx_ctrl
    import irq_pkg::*;
#(
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        int_en,
    input  logic [2:0]  irq_in,
    input  logic [2:0]  irq_mask,
    input  logic        eret,
    input  logic [31:0] pc_in,
    output logic        take_irq,
    output logic        eret_jump,
    output logic [31:0] redirect_pc,
    output logic        stall,
    output logic        enable_userBackUp,
    output logic        enable_BackUp1,
    output logic        enable_BackUp2,
    output logic        restore_userBackUp,
    output logic        restore_BackUp1,
    output logic        restore_BackUp2,
    output logic [1:0]  cur_level,
    output logic [2:0]  pending
);

    state_t      state;

    // Decision latched on RUN -> SAVE, consumed on the edge leaving SAVE.
    level_t      save_lvl;
    level_t      save_prev;
    logic [31:0] save_pc;

    // Level being returned to, latched on RUN -> RESTORE.
    level_t      rest_lvl;

    // epc_stack is indexed by the interrupted level; lvl_stack by nesting depth.
    logic [31:0] epc_stack [NUM_LEVELS];
    level_t      lvl_stack [NUM_LEVELS];
    logic [1:0]  depth;

    logic        cand_valid;
    level_t      cand_lvl;
    level_t      pop_lvl;
    logic        ret_go;
    logic        take_go;

    irq_prio_enc u_prio_enc (
        .req   (pending),
        .mask  (irq_mask),
        .valid (cand_valid),
        .level (cand_lvl)
    );

    // Top of the level stack; only meaningful when depth > 0, which ret_go
    // guarantees through cur_level > 0.
    assign pop_lvl = lvl_stack[depth - 2'd1];

    // ERET takes precedence over a simultaneous take; the request stays
    // pending and is re-evaluated against the restored level.
    assign ret_go  = (state == RUN) && eret && (cur_level != LVL_USER);
    assign take_go = (state == RUN) && !eret && int_en && cand_valid &&
                     (cand_lvl > cur_level);

    // NOTE: all state in this block uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= RUN;
            cur_level          <= LVL_USER;
            pending            <= 3'b000;
            depth              <= 2'd0;
            save_lvl           <= LVL_USER;
            save_prev          <= LVL_USER;
            save_pc            <= 32'd0;
            rest_lvl           <= LVL_USER;
            take_irq           <= 1'b0;
            eret_jump          <= 1'b0;
            redirect_pc        <= 32'd0;
            stall              <= 1'b0;
            enable_userBackUp  <= 1'b0;
            enable_BackUp1     <= 1'b0;
            enable_BackUp2     <= 1'b0;
            restore_userBackUp <= 1'b0;
            restore_BackUp1    <= 1'b0;
            restore_BackUp2    <= 1'b0;
            // NOTE: the stacks are tiny register arrays that must read as zero
            // after reset, so they are cleared explicitly rather than left to
            // power-up contents like a RAM would be.
            for (int i = 0; i < NUM_LEVELS; i++) begin
                epc_stack[i] <= 32'd0;
                lvl_stack[i] <= LVL_USER;
            end
        end else begin
            // Pulse outputs default low; only the RUN decision raises them.
            take_irq           <= 1'b0;
            eret_jump          <= 1'b0;
            redirect_pc        <= 32'd0;
            stall              <= 1'b0;
            enable_userBackUp  <= 1'b0;
            enable_BackUp1     <= 1'b0;
            enable_BackUp2     <= 1'b0;
            restore_userBackUp <= 1'b0;
            restore_BackUp1    <= 1'b0;
            restore_BackUp2    <= 1'b0;

            pending <= pending | irq_in;

            case (state)
                RUN: begin
                    if (ret_go) begin
                        state       <= RESTORE;
                        rest_lvl    <= pop_lvl;
                        stall       <= 1'b1;
                        eret_jump   <= 1'b1;
                        redirect_pc <= epc_stack[pop_lvl];
                        {restore_BackUp2, restore_BackUp1, restore_userBackUp}
                            <= level_onehot(pop_lvl);
                    end else if (take_go) begin
                        state       <= SAVE;
                        save_lvl    <= cand_lvl;
                        save_prev   <= cur_level;
                        save_pc     <= pc_in;
                        stall       <= 1'b1;
                        take_irq    <= 1'b1;
                        redirect_pc <= level_vector(VEC_BASE, VEC_STRIDE, cand_lvl);
                        {enable_BackUp2, enable_BackUp1, enable_userBackUp}
                            <= level_onehot(cur_level);
                    end
                end

                SAVE: begin
                    epc_stack[save_prev] <= save_pc;
                    lvl_stack[depth]     <= save_prev;
                    depth                <= depth + 2'd1;
                    cur_level            <= save_lvl;
                    // Overrides the OR above for the serviced bit only: a new
                    // pulse arriving in this cycle keeps it set.
                    pending[save_lvl - LVL_1] <= irq_in[save_lvl - LVL_1];
                    state                <= RUN;
                end

                RESTORE: begin
                    depth     <= depth - 2'd1;
                    cur_level <= rest_lvl;
                    state     <= RUN;
                end

                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctx_ctrl
// Self-checking bench for irq_ctx_ctrl. A behavioural model holds the context
// as a queue of saved frames plus a "what happens on the next edge" action and
// predicts every output for every cycle. Directed scenarios come first,
// followed by randomized stimulus.
// -----------------------------------------------------------------------------
module tb_irq_ctx_ctrl;

    localparam logic [31:0] VB = 32'h0000_0100;
    localparam logic [31:0] VS = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst;
    logic        int_en;
    logic [2:0]  irq_in;
    logic [2:0]  irq_mask;
    logic        eret;
    logic [31:0] pc_in;
    logic        take_irq;
    logic        eret_jump;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        enable_userBackUp, enable_BackUp1, enable_BackUp2;
    logic        restore_userBackUp, restore_BackUp1, restore_BackUp2;
    logic [1:0]  cur_level;
    logic [2:0]  pending;

    irq_ctx_ctrl #(
        .VEC_BASE   (VB),
        .VEC_STRIDE (VS)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .int_en             (int_en),
        .irq_in             (irq_in),
        .irq_mask           (irq_mask),
        .eret               (eret),
        .pc_in              (pc_in),
        .take_irq           (take_irq),
        .eret_jump          (eret_jump),
        .redirect_pc        (redirect_pc),
        .stall              (stall),
        .enable_userBackUp  (enable_userBackUp),
        .enable_BackUp1     (enable_BackUp1),
        .enable_BackUp2     (enable_BackUp2),
        .restore_userBackUp (restore_userBackUp),
        .restore_BackUp1    (restore_BackUp1),
        .restore_BackUp2    (restore_BackUp2),
        .cur_level          (cur_level),
        .pending            (pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          prev;   // level that was interrupted
        logic [31:0] epc;    // where to resume it
    } frame_t;

    frame_t      frames[$];
    int          m_level;
    logic [2:0]  m_pend;
    int          act;        // 0: nothing, 1: enter handler, 2: return
    int          act_lvl;
    logic [31:0] act_pc;

    // Expected outputs for the cycle following the most recent edge.
    logic        e_take, e_ej, e_stall;
    logic [31:0] e_pc;
    logic [5:0]  e_strobe;   // {rest2, rest1, rest_user, en2, en1, en_user}

    task automatic model_step();
        int cand;
        int new_act;
        e_take   = 1'b0;
        e_ej     = 1'b0;
        e_stall  = 1'b0;
        e_pc     = 32'd0;
        e_strobe = 6'd0;
        if (rst) begin
            frames.delete();
            m_level = 0;
            m_pend  = 3'b000;
            act     = 0;
            return;
        end
        new_act = 0;
        if (act == 0) begin
            cand = 0;
            for (int k = 0; k < 3; k++)
                if (m_pend[k] && !irq_mask[k]) cand = k + 1;
            if (eret && m_level > 0) begin
                new_act  = 2;
                e_ej     = 1'b1;
                e_stall  = 1'b1;
                e_pc     = frames[$].epc;
                e_strobe = 6'(1 << (3 + frames[$].prev));
            end else if (!eret && int_en && cand > m_level) begin
                new_act  = 1;
                act_lvl  = cand;
                act_pc   = pc_in;
                e_take   = 1'b1;
                e_stall  = 1'b1;
                e_pc     = VB + 32'(cand - 1) * VS;
                e_strobe = 6'(1 << m_level);
            end
        end else if (act == 1) begin
            frames.push_back('{m_level, act_pc});
            m_level = act_lvl;
            m_pend[act_lvl - 1] = 1'b0;
        end else begin
            m_level = frames[$].prev;
            void'(frames.pop_back());
        end
        m_pend = m_pend | irq_in;
        act    = new_act;
    endtask

    task automatic compare_all();
        logic [5:0] strobes;
        strobes = {restore_BackUp2, restore_BackUp1, restore_userBackUp,
                   enable_BackUp2, enable_BackUp1, enable_userBackUp};
        check("take_irq",  32'(take_irq),  32'(e_take));
        check("eret_jump", 32'(eret_jump), 32'(e_ej));
        check("stall",     32'(stall),     32'(e_stall));
        check("strobes",   32'(strobes),   32'(e_strobe));
        check("cur_level", 32'(cur_level), 32'(m_level));
        check("pending",   32'(pending),   32'(m_pend));
        check("strobe_onehot", 32'($countones(strobes) <= 1), 32'd1);
        if (e_take || e_ej)
            check("redirect_pc", redirect_pc, e_pc);
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic cyc(input logic [2:0] irq, input logic er);
        irq_in = irq;
        eret   = er;
        step();
        irq_in = 3'b000;
        eret   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst      = 1'b1;
        int_en   = 1'b1;
        irq_in   = 3'b000;
        irq_mask = 3'b000;
        eret     = 1'b0;
        pc_in    = 32'h0000_0400;
        act      = 0;
        m_level  = 0;
        m_pend   = 3'b000;

        // Reset, then idle.
        idle(2);
        rst = 1'b0;
        idle(10);

        // Single level-1 interrupt from user, then return.
        cyc(3'b001, 1'b0);
        idle(4);
        cyc(3'b000, 1'b1);
        idle(3);

        // Nesting: level 1 from user, level 3 from level 1, two returns.
        cyc(3'b001, 1'b0);
        idle(4);
        pc_in = 32'h0000_0500;
        cyc(3'b100, 1'b0);
        idle(4);
        cyc(3'b000, 1'b1);
        idle(3);
        cyc(3'b000, 1'b1);
        idle(3);

        // Simultaneous requests: level 2 wins, level 1 waits for return to user.
        pc_in = 32'h0000_0600;
        cyc(3'b011, 1'b0);
        idle(4);
        cyc(3'b000, 1'b1);
        idle(5);
        cyc(3'b000, 1'b1);
        idle(3);

        // Masked request stays pending, taken after unmask; no lower preemption.
        irq_mask = 3'b010;
        cyc(3'b010, 1'b0);
        idle(4);
        irq_mask = 3'b000;
        idle(4);
        cyc(3'b001, 1'b0);
        idle(4);
        cyc(3'b000, 1'b1);
        idle(5);
        cyc(3'b000, 1'b1);
        idle(3);

        // ERET and a pending level-3 request in the same RUN cycle.
        cyc(3'b001, 1'b0);
        idle(4);
        cyc(3'b100, 1'b0);
        cyc(3'b000, 1'b1);
        idle(6);
        cyc(3'b000, 1'b1);
        idle(3);

        // Reset landing on a SAVE cycle.
        cyc(3'b001, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(3);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            irq_in = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            eret   = ($urandom_range(0, 5) == 0);
            int_en = ($urandom_range(0, 15) != 0);
            rst    = ($urandom_range(0, 299) == 0);
            pc_in  = $urandom & 32'hFFFF_FFFC;
            if ((n % 50) == 0)
                irq_mask = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
